calc_engine: RTL and testbench
==============================

# calc_engine

Parametrised signed calculator core: consumes decoded key events over a valid/ready handshake and builds decimal operands. It evaluates left-to-right chained add/subtract/multiply expressions in WIDTH-bit two's complement and drives the display value, completion and overflow status. It succeeds the fixed 16-bit controller behind the keypad front end, adding:
- generic width and operand-digit limits;
- an iterative multiplier;
- chained operators;
- overflow detection with an error state.

## Interface
Parameters:
- WIDTH, 16, datapath and result width (signed two's complement), >= 8
- MAX_DIGITS, 5, maximum decimal digits accepted per operand

Ports:
- clk  in  1  clock
- RST  in  1  reset, synchronous, active-high
- key_valid  in  1  key event present
- key_ready  out  1  engine can accept a key this cycle
- key_type  in  2  0 digit, 1 operator, 2 equal, 3 clear
- key_value  in  4  digit 0-9, or operator 0 add, 1 sub, 2 mul
- display_output  out  WIDTH  value shown (signed)
- complete  out  1  result valid
- overflow  out  1  arithmetic overflow, held until clear
- current_state  out  3  state encoding, for debug

## Operation
- A key is consumed on a rising clk edge with key_valid && key_ready.
- key_ready = (state != S_COMP), combinational from state.
- Registers:
  - acc_a, acc_b (WIDTH): operands.
  - op (2): pending operator.
  - chain (1): after S_COMP, go to S_B (1) or S_RES (0).
  - ndig: digit count.
- States (current_state encoding): S_A=0, S_B=1, S_COMP=2, S_RES=3, S_ERR=4.
- Digit in S_A/S_B:
  - Updates operand ← operand*10 + d.
  - Applied only if d <= 9, ndig < MAX_DIGITS and the result <= 2^(WIDTH-1)-1.
  - Otherwise the key is consumed and ignored.
  - Operands are non-negative magnitudes.
- S_A:
  - digit: accumulate into acc_a.
  - operator: latch op, acc_b=0, ndig=0, go S_B.
  - equal: ignored.
- S_B:
  - digit: accumulate into acc_b.
  - operator: go S_COMP with chain=1; the new operator code is held as next_op.
  - equal: go S_COMP with chain=0.
  - An empty operand B evaluates as 0.
- S_COMP:
  - add/sub takes 1 cycle.
  - mul: sign-magnitude shift-add, one multiplier bit per cycle, WIDTH cycles, 2*WIDTH-bit product, then sign applied.
  - Result to acc_a.
  - Overflow (does not fit signed WIDTH; -2^(WIDTH-1) fits) → S_ERR.
  - Otherwise chain=1 → op=next_op, acc_b=0, ndig=0, S_B; chain=0 → S_RES.
- S_RES:
  - digit: acc_a=d, ndig=1, S_A.
  - operator: chain on the result (latch op, S_B).
  - equal: ignored.
- S_ERR: only clear is honoured; every other key is consumed and ignored.
- Clear (any state with key_ready=1): acc_a=acc_b=0, ndig=0, overflow=0, go S_A.
- display_output by state:
  - S_A: acc_a.
  - S_B: acc_b once any digit has been entered, else acc_a.
  - S_COMP: holds its previous value.
  - S_RES: acc_a.
  - S_ERR: 0.
- complete = (state == S_RES).
- overflow is set on entry to S_ERR.

## Timing
- Reset values: state S_A, display_output 0, complete 0, overflow 0, key_ready 1, all registers 0.
- Reset overrides everything, including a multiply in progress and a key handshake in the same cycle.
- Key effect visible on outputs the cycle after acceptance.
- Equal → complete latency: add/sub 2 cycles after acceptance; mul WIDTH+1.
- key_ready is low for exactly 1 (add/sub) or WIDTH (mul) cycles.
- key_valid asserted while key_ready=0 is neither consumed nor lost; the source must hold it.
- No combinational path from key_valid to key_ready.

## Test plan
WIDTH=16, MAX_DIGITS=5.
1. Reset, then keys 1,2,+,3,4,= → display 34 after second digit; after equal display 46 (0x002E), complete=1, key_ready low 1 cycle.
2. Keys 5,-,9,= → display 0xFFFC (-4), overflow=0; then digit 7 → complete=0, display 7, state S_A.
3. Keys 1,2,3,*,4,5,= → key_ready low exactly 16 cycles, display 5535, complete=1. Then *,9,= → 49815 overflows: S_ERR, overflow=1, display 0, digits ignored. Clear → display 0, overflow=0, S_A.
4. Chaining: 7,+,3,*,2,= → display 10 after '*' evaluation, final 20. Then -,5,0,= → -30 (0xFFE2).
5. Entry limits: 3,2,7,6,8 → 3276 (8 rejected, over 32767). Clear, then 3,2,7,6,7 → 32767. A sixth digit at MAX_DIGITS is ignored; digit value 12 is ignored.
6. Assert RST during cycle 8 of a multiply → next cycle S_A, display 0, key_ready=1, complete=0. A key held valid during S_COMP is accepted on the first cycle key_ready returns high.

Source files
------------

// File: rtl/calc_engine.sv
// Signed keypad calculator core: builds decimal operands from key events and
// evaluates chained add/sub/mul expressions with overflow detection.
module calc_engine #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [1:0]       key_type,
  input  logic [3:0]       key_value,
  output logic [WIDTH-1:0] display_output,
  output logic             complete,
  output logic             overflow,
  output logic [2:0]       current_state
);

  localparam int NDW = (MAX_DIGITS < 1) ? 1 : $clog2(MAX_DIGITS + 1);
  localparam int CW  = $clog2(WIDTH);
  localparam logic [NDW-1:0]   NDIG_MAX = NDW'(MAX_DIGITS);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH+3:0] MAX_POS  = {5'b0, {(WIDTH-1){1'b1}}};

  localparam logic [1:0] K_DIGIT = 2'd0;
  localparam logic [1:0] K_OP    = 2'd1;
  localparam logic [1:0] K_EQ    = 2'd2;
  localparam logic [1:0] K_CLR   = 2'd3;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_COMP = 3'd2,
    S_RES  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_a_q, acc_a_d, acc_b_q, acc_b_d, disp_q;
  logic [1:0]           op_q, op_d, next_op_q, next_op_d;
  logic                 chain_q, chain_d, ovf_q, ovf_d, msign_q, msign_d;
  logic [NDW-1:0]       ndig_q, ndig_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d, prod_q, prod_d, prod_step;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 accept, digit_ok, op_ok, mul_op, mul_ovf;
  logic                 comp_done, comp_ovf;
  logic [WIDTH-1:0]     operand, abs_a, mul_res, comp_res;
  logic [WIDTH+3:0]     digit_sum;
  logic [WIDTH:0]       addsub;

  assign accept    = key_valid && (state_q != S_COMP);
  assign operand   = (state_q == S_B) ? acc_b_q : acc_a_q;
  assign digit_sum = {4'b0, operand} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, key_value};
  assign digit_ok  = (key_value <= 4'd9) && (ndig_q < NDIG_MAX) && (digit_sum <= MAX_POS);
  assign op_ok     = (key_value <= 4'd2);
  assign abs_a     = acc_a_q[WIDTH-1] ? -acc_a_q : acc_a_q;

  assign addsub = (op_q == OP_SUB) ? ({acc_a_q[WIDTH-1], acc_a_q} - {acc_b_q[WIDTH-1], acc_b_q})
                                   : ({acc_a_q[WIDTH-1], acc_a_q} + {acc_b_q[WIDTH-1], acc_b_q});

  // Magnitude product must fit WIDTH-1 bits, except exactly 2^(WIDTH-1) when negative.
  assign prod_step = mplier_q[0] ? prod_q + mcand_q : prod_q;
  assign mul_ovf   = (prod_step[2*WIDTH-1:WIDTH] != '0) ||
                     (prod_step[WIDTH-1] && (!msign_q || (prod_step[WIDTH-2:0] != '0)));
  assign mul_res   = msign_q ? -prod_step[WIDTH-1:0] : prod_step[WIDTH-1:0];

  assign mul_op    = (op_q == OP_MUL);
  assign comp_done = !mul_op || (cnt_q == CNT_LAST);
  assign comp_res  = mul_op ? mul_res : addsub[WIDTH-1:0];
  assign comp_ovf  = mul_op ? mul_ovf : (addsub[WIDTH] ^ addsub[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= S_A;
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      op_q      <= '0;
      next_op_q <= '0;
      chain_q   <= 1'b0;
      ovf_q     <= 1'b0;
      ndig_q    <= '0;
      disp_q    <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      msign_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_a_q   <= acc_a_d;
      acc_b_q   <= acc_b_d;
      op_q      <= op_d;
      next_op_q <= next_op_d;
      chain_q   <= chain_d;
      ovf_q     <= ovf_d;
      ndig_q    <= ndig_d;
      disp_q    <= display_output;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      msign_q   <= msign_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_a_d   = acc_a_q;
    acc_b_d   = acc_b_q;
    op_d      = op_q;
    next_op_d = next_op_q;
    chain_d   = chain_q;
    ovf_d     = ovf_q;
    ndig_d    = ndig_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    msign_d   = msign_q;
    cnt_d     = cnt_q;

    key_ready      = (state_q != S_COMP);
    complete       = (state_q == S_RES);
    overflow       = ovf_q;
    current_state  = state_q;
    display_output = disp_q;

    case (state_q)
      S_A:     display_output = acc_a_q;
      S_B:     display_output = (ndig_q != '0) ? acc_b_q : acc_a_q;
      S_RES:   display_output = acc_a_q;
      S_ERR:   display_output = '0;
      default: display_output = disp_q;
    endcase

    case (state_q)
      S_A: begin
        if (accept && key_type == K_DIGIT && digit_ok) begin
          acc_a_d = digit_sum[WIDTH-1:0];
          ndig_d  = ndig_q + NDW'(1);
        end else if (accept && key_type == K_OP && op_ok) begin
          op_d    = key_value[1:0];
          acc_b_d = '0;
          ndig_d  = '0;
          state_d = S_B;
        end
      end
      S_B: begin
        if (accept && key_type == K_DIGIT && digit_ok) begin
          acc_b_d = digit_sum[WIDTH-1:0];
          ndig_d  = ndig_q + NDW'(1);
        end else if (accept && ((key_type == K_OP && op_ok) || key_type == K_EQ)) begin
          chain_d   = (key_type == K_OP);
          next_op_d = key_value[1:0];
          state_d   = S_COMP;
          mcand_d   = {{WIDTH{1'b0}}, abs_a};
          mplier_d  = acc_b_q;
          prod_d    = '0;
          msign_d   = acc_a_q[WIDTH-1];
          cnt_d     = '0;
        end
      end
      S_COMP: begin
        if (comp_done) begin
          acc_a_d = comp_res;
          if (comp_ovf) begin
            ovf_d   = 1'b1;
            state_d = S_ERR;
          end else if (chain_q) begin
            op_d    = next_op_q;
            acc_b_d = '0;
            ndig_d  = '0;
            state_d = S_B;
          end else begin
            state_d = S_RES;
          end
        end else begin
          prod_d   = prod_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      S_RES: begin
        if (accept && key_type == K_DIGIT && key_value <= 4'd9) begin
          acc_a_d = {{(WIDTH-4){1'b0}}, key_value};
          ndig_d  = NDW'(1);
          state_d = S_A;
        end else if (accept && key_type == K_OP && op_ok) begin
          op_d    = key_value[1:0];
          acc_b_d = '0;
          ndig_d  = '0;
          state_d = S_B;
        end
      end
      default: ;
    endcase

    if (accept && key_type == K_CLR) begin
      acc_a_d = '0;
      acc_b_d = '0;
      ndig_d  = '0;
      ovf_d   = 1'b0;
      state_d = S_A;
    end
  end

endmodule

// File: tb/tb_calc_engine.sv
// Self-checking bench for calc_engine: directed vector table, random keys
// against an arithmetic reference model, and reset/handshake corner cases.
module tb_calc_engine;
  localparam int W  = 16;
  localparam int MD = 5;
  localparam int KD = 0, KO = 1, KE = 2, KC = 3;
  localparam longint MAXP = (64'sd1 <<< (W-1)) - 1;
  localparam longint MINN = -(64'sd1 <<< (W-1));

  logic         clk = 1'b0;
  logic         RST = 1'b1;
  logic         key_valid = 1'b0;
  logic [1:0]   key_type = '0;
  logic [3:0]   key_value = '0;
  logic         key_ready, complete, overflow;
  logic [W-1:0] display_output;
  logic [2:0]   current_state;

  calc_engine #(.WIDTH(W), .MAX_DIGITS(MD)) dut (
    .clk(clk), .RST(RST), .key_valid(key_valid), .key_ready(key_ready),
    .key_type(key_type), .key_value(key_value), .display_output(display_output),
    .complete(complete), .overflow(overflow), .current_state(current_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: operands as plain integers, state as spec debug code.
  longint m_a, m_b;
  int     m_op, m_nd, m_st;
  bit     m_ovf;

  task automatic model_reset();
    m_a = 0; m_b = 0; m_op = 0; m_nd = 0; m_st = 0; m_ovf = 0;
  endtask

  function automatic logic [15:0] m_disp();
    case (m_st)
      1:       return (m_nd > 0) ? 16'(m_b) : 16'(m_a);
      4:       return 16'h0;
      default: return 16'(m_a);
    endcase
  endfunction

  task automatic model_key(input int kt, input int kv, output int busy);
    longint r;
    busy = 0;
    if (kt == KC) begin
      m_a = 0; m_b = 0; m_nd = 0; m_ovf = 0; m_st = 0;
      return;
    end
    case (m_st)
      0: begin
        if (kt == KD && kv <= 9 && m_nd < MD && m_a * 10 + kv <= MAXP) begin
          m_a = m_a * 10 + kv; m_nd++;
        end else if (kt == KO && kv <= 2) begin
          m_op = kv; m_b = 0; m_nd = 0; m_st = 1;
        end
      end
      1: begin
        if (kt == KD) begin
          if (kv <= 9 && m_nd < MD && m_b * 10 + kv <= MAXP) begin
            m_b = m_b * 10 + kv; m_nd++;
          end
        end else if ((kt == KO && kv <= 2) || kt == KE) begin
          busy = (m_op == 2) ? W : 1;
          case (m_op)
            0:       r = m_a + m_b;
            1:       r = m_a - m_b;
            default: r = m_a * m_b;
          endcase
          if (r > MAXP || r < MINN) begin
            m_st = 4; m_ovf = 1;
          end else begin
            m_a = r;
            if (kt == KO) begin
              m_op = kv; m_b = 0; m_nd = 0; m_st = 1;
            end else m_st = 3;
          end
        end
      end
      3: begin
        if (kt == KD && kv <= 9) begin
          m_a = kv; m_nd = 1; m_st = 0;
        end else if (kt == KO && kv <= 2) begin
          m_op = kv; m_b = 0; m_nd = 0; m_st = 1;
        end
      end
      default: ;
    endcase
  endtask

  // Presents one key, waits for acceptance, measures the busy window and
  // checks outputs on the first ready cycle afterwards.
  task automatic run_key(input int kt, input int kv, input logic [15:0] e_disp,
                         input bit e_c, input bit e_o, input int e_st, input int e_busy,
                         input logic [15:0] prev_disp, input string tag);
    int busy, n;
    logic [15:0] hold;
    hold = 'x;
    @(negedge clk);
    key_type = 2'(kt); key_value = 4'(kv); key_valid = 1'b1;
    n = 0;
    while (!key_ready && n < 200) begin @(negedge clk); n++; end
    if (!key_ready) begin
      tests++; fails++;
      $display("FAIL %s accept: key_ready stuck low, expected high", tag);
      key_valid = 1'b0;
      return;
    end
    @(posedge clk); #1 key_valid = 1'b0;
    busy = 0;
    @(negedge clk);
    while (!key_ready && busy < 200) begin
      if (busy == 0) hold = display_output;
      busy++;
      @(negedge clk);
    end
    check({tag, " busy"}, busy, e_busy);
    if (e_busy > 0) check({tag, " hold"}, hold, prev_disp);
    check({tag, " disp"}, display_output, e_disp);
    check({tag, " complete"}, complete, e_c);
    check({tag, " overflow"}, overflow, e_o);
    check({tag, " state"}, current_state, e_st);
  endtask

  typedef struct {
    int kt; int kv; logic [15:0] disp; bit c; bit o; int st; int busy;
  } vec_t;
  vec_t vecs[$];

  task automatic add_v(input int kt, input int kv, input logic [15:0] disp,
                       input bit c, input bit o, input int st, input int busy);
    vecs.push_back('{kt, kv, disp, c, o, st, busy});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int mb, kt, kv, r, n;
    logic [15:0] prev, last;

    // plan 1
    add_v(KD,1,1,0,0,0,0);  add_v(KD,2,12,0,0,0,0);  add_v(KO,0,12,0,0,1,0);
    add_v(KD,3,3,0,0,1,0);  add_v(KD,4,34,0,0,1,0);  add_v(KE,0,46,1,0,3,1);
    // plan 2
    add_v(KD,5,5,0,0,0,0);  add_v(KO,1,5,0,0,1,0);   add_v(KD,9,9,0,0,1,0);
    add_v(KE,0,16'hFFFC,1,0,3,1);                    add_v(KD,7,7,0,0,0,0);
    // plan 3
    add_v(KC,0,0,0,0,0,0);  add_v(KD,1,1,0,0,0,0);   add_v(KD,2,12,0,0,0,0);
    add_v(KD,3,123,0,0,0,0); add_v(KO,2,123,0,0,1,0); add_v(KD,4,4,0,0,1,0);
    add_v(KD,5,45,0,0,1,0); add_v(KE,0,5535,1,0,3,16); add_v(KO,2,5535,0,0,1,0);
    add_v(KD,9,9,0,0,1,0);  add_v(KE,0,0,0,1,4,16);  add_v(KD,3,0,0,1,4,0);
    add_v(KO,0,0,0,1,4,0);  add_v(KE,0,0,0,1,4,0);   add_v(KC,0,0,0,0,0,0);
    // plan 4
    add_v(KD,7,7,0,0,0,0);  add_v(KO,0,7,0,0,1,0);   add_v(KD,3,3,0,0,1,0);
    add_v(KO,2,10,0,0,1,1); add_v(KD,2,2,0,0,1,0);   add_v(KE,0,20,1,0,3,16);
    add_v(KO,1,20,0,0,1,0); add_v(KD,5,5,0,0,1,0);   add_v(KD,0,50,0,0,1,0);
    add_v(KE,0,16'hFFE2,1,0,3,1);
    // plan 5 entry limits
    add_v(KC,0,0,0,0,0,0);  add_v(KD,3,3,0,0,0,0);   add_v(KD,2,32,0,0,0,0);
    add_v(KD,7,327,0,0,0,0); add_v(KD,6,3276,0,0,0,0); add_v(KD,8,3276,0,0,0,0);
    add_v(KC,0,0,0,0,0,0);  add_v(KD,3,3,0,0,0,0);   add_v(KD,2,32,0,0,0,0);
    add_v(KD,7,327,0,0,0,0); add_v(KD,6,3276,0,0,0,0); add_v(KD,7,32767,0,0,0,0);
    add_v(KD,0,32767,0,0,0,0);
    // signed range edges
    add_v(KO,0,32767,0,0,1,0); add_v(KD,1,1,0,0,1,0); add_v(KE,0,0,0,1,4,1);
    add_v(KC,0,0,0,0,0,0);  add_v(KD,0,0,0,0,0,0);   add_v(KO,1,0,0,0,1,0);
    add_v(KD,3,3,0,0,1,0);  add_v(KD,2,32,0,0,1,0);  add_v(KD,7,327,0,0,1,0);
    add_v(KD,6,3276,0,0,1,0); add_v(KD,7,32767,0,0,1,0); add_v(KE,0,16'h8001,1,0,3,1);
    add_v(KO,1,16'h8001,0,0,1,0); add_v(KD,1,1,0,0,1,0); add_v(KE,0,16'h8000,1,0,3,1);
    add_v(KO,2,16'h8000,0,0,1,0); add_v(KD,1,1,0,0,1,0); add_v(KE,0,16'h8000,1,0,3,16);
    add_v(KO,1,16'h8000,0,0,1,0); add_v(KD,1,1,0,0,1,0); add_v(KE,0,0,0,1,4,1);
    add_v(KC,0,0,0,0,0,0);  add_v(KD,4,4,0,0,0,0);   add_v(KD,12,4,0,0,0,0);
    add_v(KD,5,45,0,0,0,0); add_v(KE,0,45,0,0,0,0);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    check("reset disp", display_output, 16'h0);
    check("reset complete", complete, 1'b0);
    check("reset overflow", overflow, 1'b0);
    check("reset ready", key_ready, 1'b1);
    check("reset state", current_state, 3'd0);
    model_reset();

    last = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      model_key(vecs[i].kt, vecs[i].kv, mb);
      run_key(vecs[i].kt, vecs[i].kv, vecs[i].disp, vecs[i].c, vecs[i].o,
              vecs[i].st, vecs[i].busy, last, $sformatf("vec%0d", i));
      last = vecs[i].disp;
    end

    // random keys against the model
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(99));
      if (r < 55) begin
        kt = KD;
        kv = ($urandom_range(19) == 0) ? int'($urandom_range(15, 10)) : int'($urandom_range(9));
      end else if (r < 78) begin
        kt = KO; kv = int'($urandom_range(2));
      end else if (r < 93) begin
        kt = KE; kv = int'($urandom_range(15));
      end else begin
        kt = KC; kv = int'($urandom_range(15));
      end
      prev = m_disp();
      model_key(kt, kv, mb);
      run_key(kt, kv, m_disp(), m_st == 3, m_ovf, m_st, mb, prev, $sformatf("rnd%0d", i));
    end

    // reset during cycle 8 of a multiply
    model_key(KC, 0, mb); run_key(KC, 0, 0, 0, 0, 0, 0, 0, "r6 clr");
    model_key(KD, 1, mb); run_key(KD, 1, 1, 0, 0, 0, 0, 0, "r6 d1");
    model_key(KO, 2, mb); run_key(KO, 2, 1, 0, 0, 1, 0, 1, "r6 mul");
    model_key(KD, 9, mb); run_key(KD, 9, 9, 0, 0, 1, 0, 1, "r6 d9");
    @(negedge clk);
    key_type = 2'(KE); key_value = 4'd0; key_valid = 1'b1;
    @(posedge clk); #1 key_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("r6 busy before reset", key_ready, 1'b0);
    RST = 1'b1;
    @(posedge clk); #1 RST = 1'b0;
    @(negedge clk);
    check("r6 state", current_state, 3'd0);
    check("r6 disp", display_output, 16'h0);
    check("r6 ready", key_ready, 1'b1);
    check("r6 complete", complete, 1'b0);
    model_reset();

    // reset wins over a handshake in the same cycle
    @(negedge clk);
    key_type = 2'(KD); key_value = 4'd7; key_valid = 1'b1; RST = 1'b1;
    @(posedge clk); #1 key_valid = 1'b0; RST = 1'b0;
    @(negedge clk);
    check("rk disp", display_output, 16'h0);
    check("rk state", current_state, 3'd0);

    // key held valid through a multiply is taken on the first ready cycle
    model_key(KD, 6, mb); run_key(KD, 6, 6, 0, 0, 0, 0, 0, "hk d6");
    model_key(KO, 2, mb); run_key(KO, 2, 6, 0, 0, 1, 0, 6, "hk mul");
    model_key(KD, 7, mb); run_key(KD, 7, 7, 0, 0, 1, 0, 6, "hk d7");
    @(negedge clk);
    key_type = 2'(KE); key_value = 4'd0; key_valid = 1'b1;
    @(posedge clk); #1 key_type = 2'(KD); key_value = 4'd8;
    n = 0;
    @(negedge clk);
    while (!key_ready && n < 200) begin n++; @(negedge clk); end
    check("hk busy", n, W);
    check("hk result", display_output, 16'd42);
    check("hk complete", complete, 1'b1);
    @(posedge clk); #1 key_valid = 1'b0;
    @(negedge clk);
    check("hk disp", display_output, 16'd8);
    check("hk state", current_state, 3'd0);
    check("hk complete after", complete, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
